// File: rtl/timer_pkg.sv
// Shared types and constants for the two-mode seconds timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  localparam logic [7:0] SEC_MAX_BCD = 8'h59;
  localparam logic [3:0] UNITS_MAX   = 4'd9;
  localparam logic [3:0] TENS_MAX    = 4'd5;

endpackage

// File: rtl/bcd_sec_counter.sv
// Two-digit BCD seconds register counting 00..59; clr beats inc_en.
module bcd_sec_counter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_en,
  input  logic       clr,
  output logic [7:0] count,
  output logic       at_max
);

  logic [3:0] tens;
  logic [3:0] units;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens  <= '0;
      units <= '0;
    end else if (inc_en) begin
      if (units == UNITS_MAX) begin
        units <= '0;
        tens  <= (tens == TENS_MAX) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  assign count  = {tens, units};
  // High when the next increment lands on the final second.
  assign at_max = (count == SEC_MAX_BCD - 8'd1);

endmodule

// File: rtl/timer_controller.sv
// Run/pause/clear sequencer: prescaler for the 1 s tick, FSM, and mode latch.
module timer_controller
  import timer_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int CNT_W   = $clog2(CLK_DIV) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       StartStop,
  input  logic       Clear,
  input  logic       ModeIn,
  output logic [7:0] CountBCD,
  output logic       ModeSel,
  output logic       Running,
  output logic       Done,
  output logic       Tick
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_DIV - 1);

  timer_state_e     state;
  timer_state_e     state_next;
  logic [CNT_W-1:0] presc;
  logic             tick_now;
  logic             at_max;

  // Clear outranks a pending tick, so the second is never applied on a clear edge.
  assign tick_now = (state == RUN) && (presc == PRESC_LAST) && !Clear;

  bcd_sec_counter u_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_en (tick_now),
    .clr    (Clear),
    .count  (CountBCD),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    if (Clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (StartStop) state_next = RUN;
        RUN: begin
          if (tick_now && at_max) state_next = DONE;
          else if (StartStop)     state_next = PAUSE;
        end
        PAUSE:   if (StartStop) state_next = RUN;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    Running = (state == RUN);
    Done    = (state == DONE);
  end

  // PAUSE and DONE leave the prescaler untouched so a resume continues mid-second.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      Tick    <= 1'b0;
      ModeSel <= 1'b0;
    end else begin
      Tick <= tick_now;
      if (state == IDLE) ModeSel <= ModeIn;
      if (Clear || state == IDLE) begin
        presc <= '0;
      end else if (state == RUN) begin
        presc <= tick_now ? '0 : presc + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/timer_controller.md
Name: timer_controller

Overview:
- Sequencing controller for the two-mode (count-up / count-down) seconds timer.
- Generates the 1 s tick from the system clock and runs a two-digit BCD seconds count, 0x00..0x59.
- Drives the mode-select line of the downstream reverser and 7-segment path. In count-down mode the reverser maps 0x00..0x59 to 59..00.
- Handles start/stop, pause and clear, and flags completion.

Parameters:
- CLK_DIV, 50_000_000, clock cycles per 1 s tick. Legal range >= 1; 1 means a tick every cycle.
- CNT_W, $clog2(CLK_DIV)+1, prescaler width. Derived; not overridden.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- StartStop  in  1  single-cycle pulse, debounced upstream; toggles run/pause.
- Clear  in  1  single-cycle pulse; returns to idle with count 0x00.
- ModeIn  in  1  0 = count up, 1 = count down; sampled only in IDLE.
- CountBCD  out  8  {tens, units} BCD seconds, raw up-count; feeds the reverser input.
- ModeSel  out  1  latched mode; drives the reverser mode select.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.
- Tick  out  1  one-cycle pulse on each applied second.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, CountBCD=0x00, ModeSel=0, Running=0, Done=0, Tick=0, prescaler=0. rst overrides every other input.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- IDLE:
  - ModeSel <= ModeIn every cycle; prescaler held at 0.
  - StartStop -> RUN.
- RUN:
  - Prescaler counts 0..CLK_DIV-1.
  - On the cycle the prescaler is at CLK_DIV-1: prescaler <= 0, Tick <= 1, CountBCD <= BCD increment.
  - First tick is CLK_DIV cycles after the StartStop edge.
  - StartStop -> PAUSE.
- BCD increment:
  - units 9 -> 0 with carry into tens; otherwise units+1.
  - When the result is 0x59, the same edge moves state to DONE.
  - Non-BCD values (units > 9, tens > 5) are never produced.
- PAUSE:
  - Prescaler and count hold; Tick=0.
  - StartStop -> RUN, with the prescaler resuming from its held value (no re-synchronisation).
- DONE:
  - CountBCD holds 0x59; Done=1; Tick=0.
  - StartStop ignored; only Clear or rst leaves.
- ModeSel is frozen in RUN, PAUSE and DONE; changes on ModeIn are ignored there.
- Clear in any state: next state IDLE, CountBCD=0x00, prescaler=0, Done=0. ModeSel re-samples ModeIn from the next cycle.
- Priority: rst > Clear > tick > StartStop.
- Tick and StartStop in the same RUN cycle: the tick is applied (count increments, Tick=1), then state goes to PAUSE.
  - If that tick reaches 0x59, state goes to DONE and StartStop is dropped.
- Clear and StartStop in the same cycle: Clear wins; StartStop is dropped (no auto-start).
- Outputs decode directly from state: Running = (state==RUN), Done = (state==DONE).
- CLK_DIV=1: every RUN cycle is a tick.

Decomposition:
- timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - localparam SEC_MAX_BCD = 8'h59.
  - localparam UNITS_MAX = 4'd9.
- Sub-module bcd_sec_counter:
  - two-digit mod-60 BCD register with inc_en and clr inputs.
  - outputs: count[7:0], at_max (combinational, high when the next increment yields 0x59).
- Controller holds the FSM and the prescaler.

Test Plan (CLK_DIV=4):
- rst for 2 cycles -> all outputs 0; ModeIn=1 while IDLE -> ModeSel=1 next cycle.
- StartStop at cycle 0 -> Tick at cycles 4, 8, 12; CountBCD 0x01, 0x02, 0x03; Running=1.
- Run through the 0x09 tick -> next count 0x10 (units carry); run 59 ticks total -> CountBCD=0x59, Done=1, Running=0. Further StartStop -> no change.
- Pause at prescaler=2 for 10 cycles, then resume -> next Tick exactly 2 cycles after resume; count unchanged during pause. ModeIn toggled during pause -> ModeSel unchanged.
- StartStop coincident with a tick at count 0x07 -> CountBCD=0x08, Tick=1, state PAUSE. Same collision at 0x58 -> DONE.
- Clear+StartStop same cycle in RUN at 0x23 -> IDLE, CountBCD=0x00, Running=0. rst mid-RUN -> reset values on the next edge.
